// File: rtl/rsa_uart_sequencer.sv
// Opcode-framed byte sequencer between a UART rx/tx pair and the exponent_modulus block.
// 'K' frames load (exponent, modulus) pairs into key slots; 'M' frames run a message
// against a stored key and return the KEY_WIDTH result MSB first. Every frame is
// answered with ACK, NAK or the result bytes.
module rsa_uart_sequencer #(
  parameter int MSG_WIDTH      = 16,
  parameter int KEY_WIDTH      = 32,
  parameter int NUM_KEYS       = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_valid_in,
  input  logic [7:0]           rx_data_in,
  output logic [7:0]           tx_data_out,
  output logic                 tx_ready_out,
  input  logic                 tx_busy_in,
  output logic                 expmod_ready_out,
  output logic [MSG_WIDTH-1:0] expmod_value_out,
  output logic [KEY_WIDTH-1:0] expmod_exponent_out,
  output logic [KEY_WIDTH-1:0] expmod_modulus_out,
  input  logic [KEY_WIDTH-1:0] expmod_result_in,
  input  logic                 expmod_valid_in,
  output logic                 busy_out,
  output logic                 overrun_out
);

  localparam int KB   = KEY_WIDTH / 8;
  localparam int MB   = MSG_WIDTH / 8;
  localparam int SW   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CMAX = (2 * KB > MB) ? 2 * KB : MB;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW   = $clog2(KB + 1);

  localparam logic [7:0]    OP_KEY    = 8'h4B;
  localparam logic [7:0]    OP_MSG    = 8'h4D;
  localparam logic [7:0]    ACK       = 8'h06;
  localparam logic [7:0]    NAK       = 8'h15;
  localparam logic [CW-1:0] KEY_BYTES = CW'(2 * KB);
  localparam logic [CW-1:0] MSG_BYTES = CW'(MB);

  typedef enum logic [2:0] {S_IDLE, S_SLOT, S_PAYLOAD, S_COMPUTE, S_SEND} state_t;

  state_t                   state_q;
  logic                     is_key_q;
  logic [SW-1:0]            slot_q;
  logic                     slot_bad_q;
  logic [CW-1:0]            cnt_q;
  logic [TW-1:0]            tmo_q;
  logic [LW-1:0]            left_q;
  logic [KEY_WIDTH-1:0]     out_q;
  logic [2*KEY_WIDTH-1:0]   shift_q;
  logic [2*KEY_WIDTH-1:0]   shift_d;
  logic [NUM_KEYS-1:0]      valid_q;
  logic [KEY_WIDTH-1:0]     exp_mem [NUM_KEYS];
  logic [KEY_WIDTH-1:0]     mod_mem [NUM_KEYS];
  logic [7:0]               tx_data_q;
  logic                     tx_ready_q;
  logic                     ready_q;
  logic [MSG_WIDTH-1:0]     value_q;
  logic [KEY_WIDTH-1:0]     exp_q;
  logic [KEY_WIDTH-1:0]     mod_q;
  logic                     ovr_q;

  logic                     tx_ok;
  logic                     last_byte;
  logic                     tmo_hit;
  logic                     slot_live;
  logic                     resp_go;
  logic [7:0]               resp_byte;
  logic                     cmp_go;
  logic                     key_wr;

  assign tx_data_out         = tx_data_q;
  assign tx_ready_out        = tx_ready_q;
  assign expmod_ready_out    = ready_q;
  assign expmod_value_out    = value_q;
  assign expmod_exponent_out = exp_q;
  assign expmod_modulus_out  = mod_q;
  assign overrun_out         = ovr_q;
  assign busy_out            = (state_q != S_IDLE);

  // Frame decode: decides when a one-byte ACK/NAK starts and when a valid 'M' launches expmod.
  always_comb begin
    shift_d   = {shift_q[2*KEY_WIDTH-9:0], rx_data_in};
    tx_ok     = !tx_busy_in && !tx_ready_q;
    last_byte = rx_valid_in && (cnt_q == CW'(1));
    tmo_hit   = !rx_valid_in && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    slot_live = !slot_bad_q && valid_q[slot_q];
    resp_go   = 1'b0;
    resp_byte = NAK;
    cmp_go    = 1'b0;
    case (state_q)
      S_IDLE:    resp_go = rx_valid_in && (rx_data_in != OP_KEY) && (rx_data_in != OP_MSG);
      S_SLOT:    resp_go = tmo_hit;
      S_PAYLOAD: begin
        if (tmo_hit) begin
          resp_go = 1'b1;
        end else if (last_byte) begin
          if (is_key_q) begin
            resp_go   = 1'b1;
            resp_byte = slot_bad_q ? NAK : ACK;
          end else if (slot_live) begin
            cmp_go = 1'b1;
          end else begin
            resp_go = 1'b1;
          end
        end
      end
      default: ;
    endcase
    key_wr = !rst_in && (state_q == S_PAYLOAD) && last_byte && is_key_q && !slot_bad_q;
  end

  // Payload shift register and key slot storage; contents need no reset, the valid bits gate use.
  always_ff @(posedge clk_in) begin
    if (state_q == S_PAYLOAD && rx_valid_in) shift_q <= shift_d;
    if (key_wr) begin
      exp_mem[slot_q] <= shift_d[2*KEY_WIDTH-1:KEY_WIDTH];
      mod_mem[slot_q] <= shift_d[KEY_WIDTH-1:0];
    end
  end

  // Sequencer FSM with registered tx/expmod strobes; a response may launch its first byte on entry to SEND.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      is_key_q   <= 1'b0;
      slot_q     <= '0;
      slot_bad_q <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      left_q     <= '0;
      valid_q    <= '0;
      tx_data_q  <= '0;
      tx_ready_q <= 1'b0;
      ready_q    <= 1'b0;
      value_q    <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      tx_ready_q <= 1'b0;
      ready_q    <= 1'b0;
      ovr_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_valid_in) begin
            is_key_q <= (rx_data_in == OP_KEY);
            tmo_q    <= '0;
            state_q  <= S_SLOT;
          end
        end
        S_SLOT: begin
          if (rx_valid_in) begin
            slot_q     <= rx_data_in[SW-1:0];
            slot_bad_q <= ({1'b0, rx_data_in} >= 9'(NUM_KEYS));
            cnt_q      <= is_key_q ? KEY_BYTES : MSG_BYTES;
            tmo_q      <= '0;
            state_q    <= S_PAYLOAD;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_PAYLOAD: begin
          if (rx_valid_in) begin
            cnt_q <= cnt_q - CW'(1);
            tmo_q <= '0;
            if (key_wr) valid_q[slot_q] <= 1'b1;
            if (cmp_go) begin
              value_q <= shift_d[MSG_WIDTH-1:0];
              exp_q   <= exp_mem[slot_q];
              mod_q   <= mod_mem[slot_q];
              ready_q <= 1'b1;
              state_q <= S_COMPUTE;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_COMPUTE: begin
          ovr_q <= rx_valid_in;
          if (expmod_valid_in) begin
            state_q <= S_SEND;
            if (tx_ok) begin
              tx_data_q  <= expmod_result_in[KEY_WIDTH-1 -: 8];
              tx_ready_q <= 1'b1;
              out_q      <= expmod_result_in << 8;
              left_q     <= LW'(KB - 1);
            end else begin
              out_q  <= expmod_result_in;
              left_q <= LW'(KB);
            end
          end
        end
        S_SEND: begin
          ovr_q <= rx_valid_in;
          if (left_q != '0) begin
            if (tx_ok) begin
              tx_data_q  <= out_q[KEY_WIDTH-1 -: 8];
              tx_ready_q <= 1'b1;
              out_q      <= out_q << 8;
              left_q     <= left_q - LW'(1);
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (resp_go) begin
        state_q <= S_SEND;
        tmo_q   <= '0;
        if (tx_ok) begin
          tx_data_q  <= resp_byte;
          tx_ready_q <= 1'b1;
          left_q     <= '0;
        end else begin
          out_q  <= KEY_WIDTH'(resp_byte) << (KEY_WIDTH - 8);
          left_q <= LW'(1);
        end
      end
    end
  end

endmodule
